// File: rtl/aes_key_expansion_stream_if.sv
// Key-load and round-key stream handshake bundle for aes_key_expansion_stream.
// master = key source / round-key consumer side, slave = the key expansion block.
interface aes_key_expansion_stream_if #(
    parameter int RC_W = 4
);
    logic            key_valid;
    logic            key_ready;
    logic [7:0]      key_byte;
    logic            key_len_256;
    logic            rk_valid;
    logic            rk_ready;
    logic [7:0]      rk_byte;
    logic [RC_W-1:0] rk_round;
    logic            rk_last;

    modport master (
        output key_valid, key_byte, key_len_256, rk_ready,
        input  key_ready, rk_valid, rk_byte, rk_round, rk_last
    );

    modport slave (
        input  key_valid, key_byte, key_len_256, rk_ready,
        output key_ready, rk_valid, rk_byte, rk_round, rk_last
    );
endinterface

// File: rtl/aes_key_expansion_stream.sv
// Byte-serial AES-128/256 key expansion streaming every round-key byte over valid/ready.
// Optional macro AES_KEXP_LAST_RK_EN adds a capture of the final round key (last_rk).
module aes_key_expansion_stream #(
    parameter int MAX_NK = 8,
    parameter int RC_W   = 4
) (
    input  logic clk,
    input  logic rst,
    aes_key_expansion_stream_if.slave kx,
    output logic busy
`ifdef AES_KEXP_LAST_RK_EN
    ,
    output logic [127:0] last_rk,
    output logic         last_rk_valid
`endif
);
    localparam int WB = 4 * MAX_NK;
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GEN} state_t;

    state_t      state_reg, state_next;
    logic        nk8_reg;
    logic [5:0]  load_cnt_reg;
    logic [7:0]  b_reg;
    logic [31:0] prev_reg;
    logic [3:0]  rc_reg;
    logic [7:0]  win_reg  [WB];
    logic [7:0]  win_next [WB];

    logic        key_acc, rk_hs, key_nk8, nk8_eff, echo, word_rot, word_sub, shift_en;
    logic [1:0]  j;
    logic [31:0] tail_word, cur_prev;
    logic [7:0]  sbox_in, sbox_out, rcon, t_byte, gen_byte, new_byte, last_idx;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    assign kx.key_ready = (state_reg != S_GEN);
    assign kx.rk_valid  = (state_reg == S_GEN);
    assign busy         = (state_reg != S_IDLE);

    assign key_acc  = kx.key_valid && kx.key_ready;
    assign rk_hs    = kx.rk_valid && kx.rk_ready;
    assign shift_en = key_acc || rk_hs;
    assign key_nk8  = (MAX_NK == 8) && kx.key_len_256;
    // The first key byte decides where the window tail sits before nk8_reg is loaded.
    assign nk8_eff  = (state_reg == S_IDLE) ? key_nk8 : nk8_reg;

    assign j        = b_reg[1:0];
    assign last_idx = nk8_reg ? 8'd239 : 8'd175;
    assign echo     = nk8_reg ? (b_reg < 8'd32) : (b_reg < 8'd16);
    assign word_rot = nk8_reg ? (b_reg[4:2] == 3'd0) : (b_reg[3:2] == 2'd0);
    assign word_sub = nk8_reg && (b_reg[4:2] == 3'd4);

    // w[i-1] is the newest word in the window; it is only intact at the word start.
    assign tail_word = nk8_reg ? {win_reg[WB-4], win_reg[WB-3], win_reg[WB-2], win_reg[WB-1]}
                               : {win_reg[12], win_reg[13], win_reg[14], win_reg[15]};
    assign cur_prev  = (j == 2'd0) ? tail_word : prev_reg;

    assign sbox_in  = word_rot ? word_byte(cur_prev, j + 2'd1) : word_byte(cur_prev, j);
    assign sbox_out = SBOX_TABLE[{~sbox_in, 3'b000} +: 8];

    always_comb begin
        case (rc_reg)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        t_byte = word_byte(cur_prev, j);
        if (word_rot) begin
            t_byte = sbox_out ^ ((j == 2'd0) ? rcon : 8'h00);
        end else if (word_sub) begin
            t_byte = sbox_out;
        end
    end

    assign gen_byte    = echo ? win_reg[0] : (win_reg[0] ^ t_byte);
    assign new_byte    = (state_reg == S_GEN) ? gen_byte : kx.key_byte;
    assign kx.rk_byte  = kx.rk_valid ? gen_byte : 8'h00;
    assign kx.rk_round = RC_W'(b_reg[7:4]);
    assign kx.rk_last  = kx.rk_valid && (b_reg == last_idx);

    // Window shifts toward index 0; the tail is slot 4*Nk-1.
    genvar gi;
    generate
        for (gi = 0; gi < WB; gi++) begin : g_win
            if (gi == WB - 1) begin : g_top
                assign win_next[gi] = new_byte;
            end else if (gi == 15) begin : g_mid
                assign win_next[gi] = nk8_eff ? win_reg[gi+1] : new_byte;
            end else begin : g_shift
                assign win_next[gi] = win_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (key_acc) state_next = S_LOAD;
            S_LOAD: if (key_acc && load_cnt_reg == (nk8_reg ? 6'd31 : 6'd15)) state_next = S_GEN;
            S_GEN:  if (rk_hs && kx.rk_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            nk8_reg      <= 1'b0;
            load_cnt_reg <= 6'd0;
            b_reg        <= 8'd0;
            prev_reg     <= 32'd0;
            rc_reg       <= 4'd0;
            for (int k = 0; k < WB; k++) win_reg[k] <= 8'h00;
        end else begin
            state_reg <= state_next;
            if (shift_en) begin
                for (int k = 0; k < WB; k++) win_reg[k] <= win_next[k];
            end
            if (state_reg == S_IDLE && key_acc) begin
                nk8_reg      <= key_nk8;
                load_cnt_reg <= 6'd1;
                b_reg        <= 8'd0;
                rc_reg       <= 4'd0;
            end else if (state_reg == S_LOAD && key_acc) begin
                load_cnt_reg <= load_cnt_reg + 6'd1;
            end else if (state_reg == S_GEN && rk_hs) begin
                b_reg <= b_reg + 8'd1;
                if (j == 2'd0) prev_reg <= tail_word;
                if (!echo && word_rot && j == 2'd3) rc_reg <= rc_reg + 4'd1;
            end
        end
    end

`ifdef AES_KEXP_LAST_RK_EN
    logic [127:0] last_rk_reg;
    logic         last_rk_valid_reg;
    logic [3:0]   nr;

    assign nr = nk8_reg ? 4'd14 : 4'd10;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_rk_reg       <= 128'd0;
            last_rk_valid_reg <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && key_acc) last_rk_valid_reg <= 1'b0;
            if (rk_hs && b_reg[7:4] == nr) last_rk_reg <= {last_rk_reg[119:0], kx.rk_byte};
            if (rk_hs && kx.rk_last) last_rk_valid_reg <= 1'b1;
        end
    end

    assign last_rk       = last_rk_reg;
    assign last_rk_valid = last_rk_valid_reg;
`endif
endmodule

// File: tb/tb_aes_key_expansion_stream.sv
// Scoreboard bench for aes_key_expansion_stream: a word-wise FIPS-197 model fills the
// expected queue at key load; a negedge monitor pops and compares every handshaked byte.
module tb_aes_key_expansion_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
`ifdef AES_KEXP_LAST_RK_EN
    logic [127:0] last_rk;
    logic         last_rk_valid;
`endif

    aes_key_expansion_stream_if #(.RC_W(4)) kx ();

    aes_key_expansion_stream #(.MAX_NK(8), .RC_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .kx   (kx),
        .busy (busy)
`ifdef AES_KEXP_LAST_RK_EN
        ,
        .last_rk       (last_rk),
        .last_rk_valid (last_rk_valid)
`endif
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [7:0]  sb [256];
    logic [7:0]  key_buf [32];
    logic [12:0] exp_q [$];
    logic [7:0]  got_b [240];
    logic [7:0]  ref_b [176];
    int          seen_cnt = 0, gen_cycles = 0, stall_cnt = 0, last_seen_idx = -1;
    logic [3:0]  last_round = 4'd0;
    int          ready_mode = 0;
    bit          stall_armed = 0, last_pending = 0;
    logic [13:0] stall_val;
    logic [127:0] k128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [255:0] k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in, b = b_in, p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from GF(2^8) inverse plus affine map, independent of any lookup table.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00, s, r;
        for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        s = inv;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic push_expected(input bit is256);
        int nk = is256 ? 8 : 4;
        int nr = nk + 6;
        int total = 16 * (nr + 1);
        logic [31:0] w [60];
        logic [31:0] temp, wb;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = {key_buf[4*i], key_buf[4*i+1], key_buf[4*i+2], key_buf[4*i+3]};
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int k = 0; k < total; k++) begin
            wb = w[k/4];
            exp_q.push_back({(k == total - 1), 4'(k / 16), wb[31 - 8*(k%4) -: 8]});
        end
    endtask

    task automatic load_key(input bit is256, input int gap, input bit len_flip);
        int n = is256 ? 32 : 16;
        push_expected(is256);
        @(posedge clk);
        #1;
        for (int idx = 0; idx < n; idx++) begin
            kx.key_valid   = 1'b1;
            kx.key_byte    = key_buf[idx];
            kx.key_len_256 = (idx == 0) ? is256 : (len_flip ? ~is256 : is256);
            @(negedge clk);
            check("key_ready_load", kx.key_ready, 1'b1);
            if (idx == n - 1) check("no_partial_rk", kx.rk_valid, 1'b0);
            @(posedge clk);
            #1;
            kx.key_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        check("gen_latency", kx.rk_valid, 1'b1);
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while ((exp_q.size() != 0 || kx.rk_valid) && c < 3000) begin
            @(posedge clk);
            #2;
            c++;
        end
        check("stream_done", {exp_q.size() == 0, kx.rk_valid}, 2'b10);
        $display("stream %s: bytes=%0d gen_cycles=%0d stalls=%0d", name, seen_cnt, gen_cycles, stall_cnt);
    endtask

    task automatic clear_stats();
        seen_cnt = 0;
        gen_cycles = 0;
        stall_cnt = 0;
        last_seen_idx = -1;
    endtask

    function automatic logic [127:0] got_n(input int base, input int n);
        logic [127:0] r = 128'd0;
        for (int k = 0; k < n; k++) r = {r[119:0], got_b[base+k]};
        return r;
    endfunction

    task automatic set_key128(input logic [127:0] k);
        for (int i = 0; i < 16; i++) key_buf[i] = k[127 - 8*i -: 8];
    endtask

    // rk_ready driver
    initial begin
        kx.rk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       kx.rk_ready = 1'b1;
                1:       kx.rk_ready = 1'($urandom_range(0, 1));
                default: kx.rk_ready = 1'b0;
            endcase
        end
    end

    // Output monitor / scoreboard consumer
    initial begin
        logic [12:0] exp_v;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_armed = 0;
                last_pending = 0;
            end else begin
                if (stall_armed) begin
                    check("stall_hold", {kx.rk_valid, kx.rk_last, kx.rk_round, kx.rk_byte}, stall_val);
                    stall_armed = 0;
                end
                if (kx.rk_valid) begin
                    gen_cycles++;
                    check("key_ready_gen", kx.key_ready, 1'b0);
                end
`ifdef AES_KEXP_LAST_RK_EN
                if (last_pending) begin
                    check("last_rk_valid_rise", last_rk_valid, 1'b1);
                    last_pending = 0;
                end
                if (kx.rk_valid && kx.rk_ready && kx.rk_last) begin
                    check("last_rk_valid_pre", last_rk_valid, 1'b0);
                    last_pending = 1;
                end
`endif
                if (kx.rk_valid && !kx.rk_ready) begin
                    stall_armed = 1;
                    stall_val = {1'b1, kx.rk_last, kx.rk_round, kx.rk_byte};
                    stall_cnt++;
                end
                if (kx.rk_valid && kx.rk_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rk_extra", exp_q.size(), 1);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("rk_stream", {kx.rk_last, kx.rk_round, kx.rk_byte}, exp_v);
                    end
                    if (seen_cnt < 240) got_b[seen_cnt] = kx.rk_byte;
                    seen_cnt++;
                    if (kx.rk_last) begin
                        last_round = kx.rk_round;
                        last_seen_idx = seen_cnt - 1;
                    end
                end
            end
        end
    end

    initial begin
        int c;
        int mism;
        for (int x = 0; x < 256; x++) sb[x] = sbox_calc(8'(x));
        kx.key_valid = 1'b0;
        kx.key_byte = 8'h00;
        kx.key_len_256 = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_key_ready", kx.key_ready, 1'b1);
        check("rst_outputs", {kx.rk_valid, busy, kx.rk_last, kx.rk_round, kx.rk_byte}, 15'd0);
`ifdef AES_KEXP_LAST_RK_EN
        check("rst_last_rk_valid", last_rk_valid, 1'b0);
`endif

        // AES-128 vector, ready held high
        set_key128(k128);
        clear_stats();
        load_key(1'b0, 0, 1'b0);
        wait_done("aes128");
        check("a128_echo", got_n(0, 16), k128);
        check("a128_w4", got_n(16, 4), 32'ha0fafe17);
        check("a128_r10", got_n(160, 16), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("a128_last_idx", last_seen_idx, 175);
        check("a128_cycles", gen_cycles, 176);
        check("a128_bytes", seen_cnt, 176);
`ifdef AES_KEXP_LAST_RK_EN
        check("a128_last_rk", last_rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("a128_last_rk_valid", last_rk_valid, 1'b1);
`endif
        for (int k = 0; k < 176; k++) ref_b[k] = got_b[k];

        // AES-256 vector
        for (int i = 0; i < 32; i++) key_buf[i] = k256[255 - 8*i -: 8];
        clear_stats();
        load_key(1'b1, 0, 1'b0);
        wait_done("aes256");
        check("a256_w8", got_n(32, 4), 32'h9ba35411);
        check("a256_r14", got_n(224, 16), 128'hfe4890d1e6188d0b046df344706c631e);
        check("a256_round", last_round, 4'd14);
        check("a256_bytes", seen_cnt, 240);

        // AES-128 vector with random back-pressure
        set_key128(k128);
        clear_stats();
        ready_mode = 1;
        load_key(1'b0, 0, 1'b0);
        wait_done("aes128_stall");
        ready_mode = 0;
        mism = 0;
        for (int k = 0; k < 176; k++) if (got_b[k] !== ref_b[k]) mism++;
        check("stall_stream_eq", mism, 0);
        check("stall_seen", stall_cnt > 0, 1'b1);

        // Gapped key load, key_len_256 toggled after the first byte
        clear_stats();
        load_key(1'b0, 2, 1'b1);
        wait_done("aes128_gaps");
        check("gaps_bytes", seen_cnt, 176);

        // Abort mid-GEN with key_valid held high, then a fresh key
        for (int i = 0; i < 16; i++) key_buf[i] = 8'($urandom);
        clear_stats();
        load_key(1'b0, 0, 1'b0);
        kx.key_valid = 1'b1;
        kx.key_byte = 8'hff;
        c = 0;
        while (seen_cnt != 90 && c < 500) begin
            @(posedge clk);
            c++;
        end
        check("rst_point", seen_cnt, 90);
        ready_mode = 2;
        #1;
        rst = 1'b1;
        kx.key_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ready_mode = 0;
        @(negedge clk);
        check("abort_key_ready", kx.key_ready, 1'b1);
        check("abort_outputs", {kx.rk_valid, busy, kx.rk_round}, 6'd0);
`ifdef AES_KEXP_LAST_RK_EN
        check("abort_last_rk_valid", last_rk_valid, 1'b0);
`endif
        set_key128(k128);
        clear_stats();
        load_key(1'b0, 0, 1'b0);
        wait_done("aes128_after_rst");
        check("restart_first", got_n(0, 16), k128);
        check("restart_r10", got_n(160, 16), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("restart_bytes", seen_cnt, 176);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
